// File: rtl/uart_word_streamer.sv
// Captures a word on each rising edge of send_i into a small FIFO and sends it as WORD_W/8
// UART frames. Define STREAM_PARITY_EN to append a parity bit to every frame.
module uart_word_streamer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CLK_DIV_W = 16,
  parameter int unsigned LE_ORDER  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WORD_W-1:0]          word_i,
  input  logic                       send_i,
  input  logic [CLK_DIV_W-1:0]       baud_div_i,
  input  logic                       parity_odd_i,
  input  logic                       stop2_i,
  input  logic                       clr_ovf_i,
  output logic                       uart_txd_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
  output logic                       overflow_o,
  output logic                       baud_tick_o
);
  localparam int unsigned Bytes = WORD_W / 8;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef STREAM_PARITY_EN
    StParity,
`endif
    StStop1,
    StStop2
  } state_e;

  state_e               state_q, state_d;
  logic                 send_q;
  logic                 cap, push, pop, tick, start_frame, byte_done;
  logic [WORD_W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [CLK_DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [IdxW-1:0]      byte_idx_q, byte_idx_d, byte_sel;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic [7:0]           byte_d;
`ifdef STREAM_PARITY_EN
  logic                 odd_q, odd_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cap  = send_i & ~send_q;
  assign pop  = (state_q == StIdle) && (level_q != '0);
  // A full FIFO still accepts a capture when a word leaves in the same cycle.
  assign push = cap & ((level_q < LvlW'(DEPTH)) | pop);

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    ovf_d = clr_ovf_i ? 1'b0 : ovf_q;
    if (cap && !push) ovf_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    stop2_d     = stop2_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
`ifdef STREAM_PARITY_EN
    odd_d       = odd_q;
`endif
    start_frame = 1'b0;
    byte_done   = 1'b0;
    tick        = (state_q != StIdle) && (cnt_q == '0);
    if (state_q != StIdle && !tick) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          word_d      = mem_q[rd_ptr_q];
          byte_idx_d  = '0;
          start_frame = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
          cnt_d     = div_q;
        end
      end
      StData: begin
        if (tick) begin
          cnt_d = div_q;
`ifdef STREAM_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = StParity;
`else
          if (bit_idx_q == 3'd7) state_d = StStop1;
`endif
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
`ifdef STREAM_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop1;
          cnt_d   = div_q;
        end
      end
`endif
      StStop1: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = StStop2;
            cnt_d   = div_q;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
      StStop2: begin
        if (tick) byte_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (byte_done) begin
      if (byte_idx_q != IdxW'(Bytes - 1)) begin
        byte_idx_d  = byte_idx_q + 1'b1;
        start_frame = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end

    // Line settings are latched per frame so mid-frame changes cannot corrupt it.
    if (start_frame) begin
      state_d = StStart;
      cnt_d   = baud_div_i;
      div_d   = baud_div_i;
      stop2_d = stop2_i;
`ifdef STREAM_PARITY_EN
      odd_d   = parity_odd_i;
`endif
    end
  end

  always_comb begin
    byte_sel = (LE_ORDER != 0) ? byte_idx_d : IdxW'(Bytes - 1) - byte_idx_d;
    byte_d   = word_d[{byte_sel, 3'b000} +: 8];
    txd_d    = 1'b1;
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = byte_d[bit_idx_d];
`ifdef STREAM_PARITY_EN
      StParity: txd_d = (^byte_d) ^ odd_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      send_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      word_q     <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
`ifdef STREAM_PARITY_EN
      odd_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      send_q     <= send_i;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      word_q     <= word_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
`ifdef STREAM_PARITY_EN
      odd_q      <= odd_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_i;
  end

  assign uart_txd_o   = txd_q;
  assign busy_o       = (state_q != StIdle) || (level_q != '0);
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;
  assign baud_tick_o  = tick;

endmodule

// File: tb/tb_uart_word_streamer.sv
// Directed bench for uart_word_streamer: stimulus pushes expected bytes into a queue and a
// serial-line monitor decodes uart_txd_o frames and pops/compares them.
`timescale 1ns/1ps
module tb_uart_word_streamer;
`ifdef STREAM_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word;
  logic        send;
  logic [15:0] baud_div;
  logic        parity_odd, stop2, clr_ovf;
  logic        txd, busy, ovf, btick;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cnt = 0;
  logic [7:0] exp_q[$];
  int start_log[$];

  uart_word_streamer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .word_i       (word),
    .send_i       (send),
    .baud_div_i   (baud_div),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .clr_ovf_i    (clr_ovf),
    .uart_txd_o   (txd),
    .busy_o       (busy),
    .fifo_level_o (level),
    .overflow_o   (ovf),
    .baud_tick_o  (btick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (btick === 1'b1) tick_cnt <= tick_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_send(input logic [31:0] w);
    word = w;
    send = 1'b1;
    clk_wait(1);
    send = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name, input int bound, output int at);
    int n;
    n = 0;
    while (busy && n < bound) begin
      clk_wait(1);
      n++;
    end
    at = cyc;
    check(name, busy, 1'b0);
  endtask

  // Decodes one frame whose first start-bit clock was just sampled; every bit must hold
  // its value for exactly baud_div+1 clocks.
  task automatic rx_frame(output logic [7:0] data, output logic par_bit, output logic fmt_ok,
                          output bit aborted);
    int nb, n;
    logic b;
    data = '0; par_bit = 1'b0; fmt_ok = 1'b1; aborted = 1'b0; b = 1'b1;
    nb = 10 + ParBits + (stop2 ? 1 : 0);
    n  = int'(baud_div) + 1;
    for (int k = 0; k < nb && !aborted; k++) begin
      for (int j = 0; j < n && !aborted; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        else if (j == 0) b = txd;
        else if (txd !== b) fmt_ok = 1'b0;
      end
      if (!aborted) begin
        if (k == 0) begin
          if (b !== 1'b0) fmt_ok = 1'b0;
        end else if (k <= 8) begin
          data[k-1] = b;
        end else if (k == 9 && ParBits == 1) begin
          par_bit = b;
        end else if (b !== 1'b1) begin
          fmt_ok = 1'b0;
        end
      end
    end
  endtask

  initial begin : monitor
    logic [7:0] d, e;
    logic       pb, ok;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        start_log.push_back(cyc);
        rx_frame(d, pb, ok, ab);
        if (!ab) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: actual %0h required no frame", d);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", d, e);
            check("frame_format", ok, 1'b1);
            if (ParBits == 1) check("frame_parity", pb, parity_odd ? ~^e : ^e);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int at, c2, t0, n0, peak;
    logic [31:0] t7w[6];
    rst_n = 1'b0; send = 1'b0; word = '0; baud_div = 16'd3;
    parity_odd = 1'b0; stop2 = 1'b0; clr_ovf = 1'b0;

    // T1: reset with send toggling
    clk_wait(1);
    send = 1'b1;
    clk_wait(1);
    send = 1'b0;
    check("t1_rst_txd", txd, 1'b1);
    check("t1_rst_level", level, 3'd0);
    check("t1_rst_ovf", ovf, 1'b0);
    check("t1_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    clk_wait(3);
    check("t1_post_busy", busy, 1'b0);
    check("t1_post_txd", txd, 1'b1);
    check("t1_post_tick", btick, 1'b0);

    // T2: basic word, 4 clocks per bit
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
    t0 = tick_cnt;
    n0 = start_log.size();
    pulse_send(32'hA5C31234);
    check("t2_capture_level", level, 3'd1);
    check("t2_txd_before_start", txd, 1'b1);
    clk_wait(1);
    c2 = cyc;
    check("t2_start_bit", txd, 1'b0);
    check("t2_popped_level", level, 3'd0);
    wait_idle("t2_idle", 400, at);
    check("t2_busy_fall", at, c2 + 160);
    clk_wait(2);
    check("t2_ticks", tick_cnt - t0, 40);
    check("t2_frame_count", start_log.size() - n0, 4);
    if (start_log.size() >= n0 + 4)
      for (int k = 0; k < 4; k++) check("t2_frame_start", start_log[n0+k], c2 + 40 * k);

    // T3: two stop bits / parity, then odd parity with one stop bit
    stop2 = 1'b1; parity_odd = 1'b0;
    exp_q.push_back(8'h34); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    pulse_send(32'h00000034);
    clk_wait(1);
    c2 = cyc;
    wait_idle("t3_idle_a", 400, at);
    check("t3_len_stop2", at, c2 + 4 * 4 * (11 + ParBits));
    stop2 = 1'b0; parity_odd = 1'b1;
    exp_q.push_back(8'h34); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    pulse_send(32'h00000034);
    clk_wait(1);
    c2 = cyc;
    wait_idle("t3_idle_b", 400, at);
    check("t3_len_stop1", at, c2 + 4 * 4 * (10 + ParBits));
    parity_odd = 1'b0;
    clk_wait(2);

    // T4: overflow with a slow line; the frame in flight is abandoned by reset
    baud_div = 16'd100;
    for (int i = 0; i < 6; i++) begin
      pulse_send(32'h10000000 + i);
      clk_wait(2);
    end
    check("t4_level_full", level, 3'd4);
    check("t4_overflow_set", ovf, 1'b1);
    clr_ovf = 1'b1;
    pulse_send(32'hBAD0BAD0);
    clr_ovf = 1'b0;
    check("t4_set_wins", ovf, 1'b1);
    clr_ovf = 1'b1;
    clk_wait(1);
    clr_ovf = 1'b0;
    check("t4_overflow_clr", ovf, 1'b0);
    check("t4_level_kept", level, 3'd4);
    rst_n = 1'b0;
    clk_wait(1);
    rst_n = 1'b1;
    check("t4_flush_level", level, 3'd0);
    clk_wait(2);

    // T5: send held high for 50 clocks captures once
    baud_div = 16'd1;
    push_word(32'h0F0E0D0C);
    word = 32'h0F0E0D0C;
    send = 1'b1;
    peak = 0;
    for (int i = 0; i < 50; i++) begin
      clk_wait(1);
      if (int'(level) > peak) peak = int'(level);
      word = 32'hFFFF0000 ^ i;
    end
    send = 1'b0;
    check("t5_peak_level", peak, 1);
    wait_idle("t5_idle", 400, at);
    check("t5_no_overflow", ovf, 1'b0);
    clk_wait(2);

    // T7: one clock per bit, full FIFO, capture coinciding with a pop, pointer wrap
    baud_div = 16'd0;
    for (int i = 0; i < 6; i++) begin
      t7w[i] = 32'h03020100 + 32'h10101010 * i;
      push_word(t7w[i]);
    end
    for (int i = 0; i < 5; i++) begin
      pulse_send(t7w[i]);
      if (i < 4) clk_wait(2);
    end
    check("t7_full_level", level, 3'd4);
    clk_wait(29);
    check("t7_level_pre_pop", level, 3'd4);
    pulse_send(t7w[5]);
    check("t7_push_pop_level", level, 3'd4);
    check("t7_push_pop_no_ovf", ovf, 1'b0);
    wait_idle("t7_idle", 1000, at);
    clk_wait(2);
    check("t7_all_frames", exp_q.size(), 0);

    // T6: reset during data bit 3 of byte 1, then a clean word
    baud_div = 16'd3;
    push_word(32'h11223344);
    pulse_send(32'h11223344);
    clk_wait(57);
    check("t6_mid_data_txd", txd, 1'b0);
    rst_n = 1'b0;
    clk_wait(1);
    check("t6_rst_txd", txd, 1'b1);
    check("t6_rst_level", level, 3'd0);
    check("t6_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    check("t6_bytes_left", exp_q.size(), 3);
    exp_q.delete();
    clk_wait(2);
    push_word(32'hDEADBEEF);
    pulse_send(32'hDEADBEEF);
    wait_idle("t6_idle", 400, at);
    clk_wait(2);

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
